// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: operator codes, FSM states,
// flag bit positions and operator classification.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WB    = 3'd5
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_ARITH = 3'd0,
    CLS_LOGIC = 3'd1,
    CLS_SHIFT = 3'd2,
    CLS_UNARY = 3'd3,
    CLS_UNDEF = 3'd4
  } op_class_e;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_ADC = 5'd2;
  localparam logic [4:0] OP_SBC = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_CMP = 5'd7;
  localparam logic [4:0] OP_MOV = 5'd8;
  localparam logic [4:0] OP_NEG = 5'd16;
  localparam logic [4:0] OP_COM = 5'd17;
  localparam logic [4:0] OP_LSL = 5'd18;
  localparam logic [4:0] OP_LSR = 5'd19;
  localparam logic [4:0] OP_ROL = 5'd20;
  localparam logic [4:0] OP_ROR = 5'd21;
  localparam logic [4:0] OP_RLC = 5'd22;
  localparam logic [4:0] OP_RRC = 5'd23;

  // Status register layout is {C,V,Z,N}.
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: cls = CLS_ARITH;
      OP_AND, OP_OR, OP_XOR, OP_MOV:          cls = CLS_LOGIC;
      OP_LSL, OP_LSR, OP_RLC, OP_RRC:         cls = CLS_SHIFT;
      OP_NEG, OP_COM, OP_ROL, OP_ROR:         cls = CLS_UNARY;
      default:                                cls = CLS_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_sequencer_flag_update.sv
// Combinational next-value of the {C,V,Z,N} status register from the
// operator class and the sampled ALU outputs.
module alu_flag_update
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  op_class_e             cls_i,
  input  logic [3:0]            flags_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  carry_i,
  input  logic                  overflow_i,
  output logic [3:0]            flags_o
);

  always_comb begin
    flags_o = flags_i;
    if (cls_i != CLS_UNDEF) begin
      flags_o[FLAG_Z] = (result_i == '0);
      flags_o[FLAG_N] = result_i[DATA_WIDTH-1];
    end
    case (cls_i)
      CLS_ARITH: begin
        flags_o[FLAG_C] = carry_i;
        flags_o[FLAG_V] = overflow_i;
      end
      CLS_LOGIC: flags_o[FLAG_V] = 1'b0;
      CLS_SHIFT: flags_o[FLAG_C] = carry_i;
      default:   ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: reads operands, fires one ALU strobe, writes the
// result back, updates status flags and pulses done for one instruction.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int REG_AW      = 3,
  parameter int RESULT_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [REG_AW-1:0]     req_rd,
  input  logic [REG_AW-1:0]     req_rs,
  input  logic                  req_imm_en,
  input  logic [DATA_WIDTH-1:0] req_imm,
  output logic [REG_AW-1:0]     rf_raddr1,
  output logic [REG_AW-1:0]     rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [4:0]            alu_operator,
  output logic [DATA_WIDTH-1:0] alu_value1,
  output logic [DATA_WIDTH-1:0] alu_value2,
  output logic                  alu_old_sign,
  output logic                  alu_compute,
  output logic                  alu_compute_single,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  output logic [3:0]            flags,
  output logic                  done,
  output logic                  err,
  output seq_state_e            dbg_state
);

  localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  seq_state_e            state_q;
  logic [4:0]            op_q;
  logic [REG_AW-1:0]     rd_q, rs_q, waddr_q;
  logic                  imm_en_q;
  logic [DATA_WIDTH-1:0] imm_q, value1_q, value2_q, wdata_q;
  logic                  compute_q, single_q, we_q, done_q, err_q, ready_q;
  logic [3:0]            flags_q, flags_d;
  logic [WAIT_W-1:0]     wait_q;

  op_class_e cls;
  logic      op_defined;
  logic      op_writes;

  assign cls        = op_class(op_q);
  assign op_defined = (cls != CLS_UNDEF);
  assign op_writes  = op_defined && (op_q != OP_CMP);

  alu_flag_update #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_flag_update (
    .cls_i     (cls),
    .flags_i   (flags_q),
    .result_i  (alu_result),
    .carry_i   (alu_carry),
    .overflow_i(alu_overflow),
    .flags_o   (flags_d)
  );

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so anything
  // presented while busy is simply not sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      value1_q  <= '0;
      value2_q  <= '0;
      compute_q <= 1'b0;
      single_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      wait_q    <= '0;
    end else begin
      compute_q <= 1'b0;
      single_q  <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            rd_q     <= req_rd;
            rs_q     <= req_rs;
            imm_en_q <= req_imm_en;
            imm_q    <= req_imm;
            ready_q  <= 1'b0;
            state_q  <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_LATCH;
        ST_LATCH: begin
          value1_q  <= rf_rdata1;
          value2_q  <= imm_en_q ? imm_q : rf_rdata2;
          compute_q <= op_defined && !op_q[4];
          single_q  <= op_defined && op_q[4];
          state_q   <= ST_EXEC;
        end
        ST_EXEC: begin
          wait_q  <= WAIT_W'(RESULT_WAIT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            done_q  <= 1'b1;
            err_q   <= !op_defined;
            state_q <= ST_WB;
            if (op_defined) flags_q <= flags_d;
            if (op_writes) begin
              we_q    <= 1'b1;
              waddr_q <= rd_q;
              wdata_q <= alu_result;
            end
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_WB: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready          = ready_q;
  assign rf_raddr1          = rd_q;
  assign rf_raddr2          = rs_q;
  assign rf_we              = we_q;
  assign rf_waddr           = waddr_q;
  assign rf_wdata           = wdata_q;
  assign alu_operator       = op_q;
  assign alu_value1         = value1_q;
  assign alu_value2         = value2_q;
  assign alu_old_sign       = value1_q[DATA_WIDTH-1];
  assign alu_compute        = compute_q;
  assign alu_compute_single = single_q;
  assign flags              = flags_q;
  assign done               = done_q;
  assign err                = err_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and an
// edge-triggered ALU model around it.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rd, req_rs;
  logic        req_imm_en;
  logic [15:0] req_imm;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic [4:0]  alu_operator;
  logic [15:0] alu_value1, alu_value2, alu_result;
  logic        alu_old_sign, alu_compute, alu_compute_single;
  logic        alu_carry, alu_overflow;
  logic [3:0]  flags;
  logic        done, err;
  seq_state_e  dbg_state;

  int checks;
  int failures;

  alu_sequencer #(
    .DATA_WIDTH(16),
    .REG_AW(3),
    .RESULT_WAIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_imm_en(req_imm_en), .req_imm(req_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_operator(alu_operator), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_old_sign(alu_old_sign), .alu_compute(alu_compute),
    .alu_compute_single(alu_compute_single),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .flags(flags), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  logic [15:0] regs [8];
  logic        poke_en;
  logic [2:0]  poke_addr;
  logic [15:0] poke_data;

  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    if (poke_en) regs[poke_addr] <= poke_data;
  end

  // ---------------- ALU model ----------------
  function automatic logic [17:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] t;
    logic        c, v;
    logic [15:0] r;
    c = 1'b0; v = 1'b0; r = a; t = '0;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: begin r = a & b; c = 1'b1; end
      OP_MOV: begin r = b; c = 1'b1; end
      OP_LSL: begin r = {a[14:0], 1'b0}; c = a[15]; end
      OP_NEG: begin r = ~a + 16'd1; c = (a != 16'd0); v = (a == 16'h8000); end
      default: r = a;
    endcase
    return {c, v, r};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      alu_result <= '0; alu_carry <= 1'b0; alu_overflow <= 1'b0;
    end else if (alu_compute || alu_compute_single) begin
      {alu_carry, alu_overflow, alu_result} <= alu_fn(alu_operator, alu_value1, alu_value2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  int   r_done_cyc, r_comp, r_single, r_both, r_we, r_ready_busy, r_wait;
  logic r_err;

  task automatic run_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic ie, input logic [15:0] imm, input logic hold);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs;
    req_imm_en = ie; req_imm = imm;
    r_wait = 0;
    while (!req_ready && r_wait < 10) begin
      @(negedge clk);
      r_wait++;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_op = OP_ADD; req_rd = 3'd7; req_rs = 3'd7; req_imm_en = 1'b1; req_imm = 16'hDEAD;
    end else begin
      req_valid = 1'b0;
    end
    r_done_cyc = 0; r_comp = 0; r_single = 0; r_both = 0; r_we = 0; r_ready_busy = 0;
    r_err = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (alu_compute) r_comp++;
      if (alu_compute_single) r_single++;
      if (alu_compute && alu_compute_single) r_both++;
      if (rf_we) r_we++;
      if (req_ready) r_ready_busy++;
      if (done) begin
        r_done_cyc = cyc;
        r_err = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  int first_done, first_ready_busy, cnt_done, cnt_we;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs = '0;
    req_imm_en = 1'b0; req_imm = '0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_strobes", 32'({alu_compute, alu_compute_single}), 32'd0);
    check("rst_value1", 32'(alu_value1), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    rst_n = 1'b1;
    @(negedge clk);
    poke(3'd0, 16'h0000); poke(3'd1, 16'h7FFF); poke(3'd2, 16'h0001); poke(3'd3, 16'h8001);
    poke(3'd4, 16'hFF00); poke(3'd5, 16'h0000); poke(3'd6, 16'h0001); poke(3'd7, 16'h0004);

    // ADD r1=0x7FFF + r2=0x0001
    run_op(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0);
    check("add_wait", 32'(r_wait), 32'd0);
    check("add_done_cyc", 32'(r_done_cyc), 32'd5);
    check("add_comp", 32'(r_comp), 32'd1);
    check("add_single", 32'(r_single), 32'd0);
    check("add_we", 32'(r_we), 32'd1);
    check("add_err", 32'(r_err), 32'd0);
    check("add_flags", 32'(flags), 32'b0101);
    check("add_old_sign", 32'(alu_old_sign), 32'd0);
    @(negedge clk);
    check("add_r1", 32'(regs[1]), 32'h8000);

    // LSL r3=0x8001: C from shift, V kept at 1
    run_op(OP_LSL, 3'd3, 3'd0, 1'b0, 16'h0, 1'b0);
    check("lsl_done_cyc", 32'(r_done_cyc), 32'd5);
    check("lsl_comp", 32'(r_comp), 32'd0);
    check("lsl_single", 32'(r_single), 32'd1);
    check("lsl_flags", 32'(flags), 32'b1100);
    check("lsl_old_sign", 32'(alu_old_sign), 32'd1);
    @(negedge clk);
    check("lsl_r3", 32'(regs[3]), 32'h0002);

    // AND r4=0xFF00 & imm 0x8F00: V cleared, C kept at 1
    run_op(OP_AND, 3'd4, 3'd0, 1'b1, 16'h8F00, 1'b0);
    check("and_comp", 32'(r_comp), 32'd1);
    check("and_flags", 32'(flags), 32'b1001);
    @(negedge clk);
    check("and_r4", 32'(regs[4]), 32'h8F00);

    // CMP r1=0x0005 against imm 0x0005
    poke(3'd1, 16'h0005);
    run_op(OP_CMP, 3'd1, 3'd2, 1'b1, 16'h0005, 1'b0);
    check("cmp_done_cyc", 32'(r_done_cyc), 32'd5);
    check("cmp_comp", 32'(r_comp), 32'd1);
    check("cmp_we", 32'(r_we), 32'd0);
    check("cmp_flags", 32'(flags), 32'b0010);
    @(negedge clk);
    check("cmp_r1", 32'(regs[1]), 32'h0005);

    // Undefined operator 31
    run_op(5'd31, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0);
    check("undef_done_cyc", 32'(r_done_cyc), 32'd5);
    check("undef_err", 32'(r_err), 32'd1);
    check("undef_comp", 32'(r_comp), 32'd0);
    check("undef_single", 32'(r_single), 32'd0);
    check("undef_we", 32'(r_we), 32'd0);
    check("undef_flags", 32'(flags), 32'b0010);
    @(negedge clk);
    check("undef_r1", 32'(regs[1]), 32'h0005);

    // NEG r6=0x0001: C and V kept
    run_op(OP_NEG, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0);
    check("neg_single", 32'(r_single), 32'd1);
    check("neg_flags", 32'(flags), 32'b0001);
    @(negedge clk);
    check("neg_r6", 32'(regs[6]), 32'hFFFF);

    // Back-to-back with req_valid held high and junk presented while busy
    run_op(OP_MOV, 3'd5, 3'd0, 1'b1, 16'h1234, 1'b1);
    first_done = r_done_cyc;
    first_ready_busy = r_ready_busy;
    check("b2b1_done_cyc", 32'(first_done), 32'd5);
    check("b2b1_ready_busy", 32'(first_ready_busy), 32'd0);
    check("b2b1_flags", 32'(flags), 32'b0000);
    run_op(OP_ADD, 3'd5, 3'd7, 1'b0, 16'h0, 1'b0);
    check("b2b2_wait", 32'(r_wait), 32'd1);
    check("b2b2_done_cyc", 32'(r_done_cyc), 32'd5);
    check("b2b2_both", 32'(r_both), 32'd0);
    @(negedge clk);
    check("b2b2_r5", 32'(regs[5]), 32'h1238);
    check("b2b_r7_untouched", 32'(regs[7]), 32'h0004);

    // ADD producing zero with carry out
    run_op(OP_ADD, 3'd1, 3'd0, 1'b1, 16'hFFFB, 1'b0);
    check("addz_flags", 32'(flags), 32'b1010);
    @(negedge clk);
    check("addz_r1", 32'(regs[1]), 32'h0000);

    // Reset asserted in the middle of WAIT
    req_valid = 1'b1; req_op = OP_ADD; req_rd = 3'd2; req_rs = 3'd3;
    req_imm_en = 1'b0; req_imm = '0;
    r_wait = 0;
    while (!req_ready && r_wait < 10) begin
      @(negedge clk);
      r_wait++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_strobes", 32'({alu_compute, alu_compute_single}), 32'd0);
    check("mid_rst_value1", 32'(alu_value1), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0; cnt_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (rf_we) cnt_we++;
    end
    check("mid_no_done", 32'(cnt_done), 32'd0);
    check("mid_no_we", 32'(cnt_we), 32'd0);
    check("mid_r2_unchanged", 32'(regs[2]), 32'h0001);

    // Recovery: MOV r2 <- 0, C starts from cleared flags
    run_op(OP_MOV, 3'd2, 3'd0, 1'b1, 16'h0000, 1'b0);
    check("rec_done_cyc", 32'(r_done_cyc), 32'd5);
    check("rec_flags", 32'(flags), 32'b0010);
    @(negedge clk);
    check("rec_r2", 32'(regs[2]), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
